vy_stream_sequencer: RTL and testbench

- Synthesizable, parametrised successor to the verify bench's load sequencer.
- Reads signature-verify operands from a word-addressed operand store and streams them, in order rho, c, z, t1, mlen, m, h, over the valid/ready input port of combined_top in verify mode.
- Captures the accept/reject result word and measures the cycle count of each verification.
- Supports data widths 32/64, all three security levels, and variable message length under full backpressure.

---
 rtl/vy_stream_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_vy_stream_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vy_stream_sequencer.sv
// vy_stream_sequencer
//   Streams signature-verify operands (rho, c, z, t1, mlen, m, h) from a
//   word-addressed operand store into the verify-mode valid/ready input of
//   combined_top, then captures the accept/reject result and the cycle count.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, sec_lvl, mlen     launch pulse; security level and message length sampled with it
//   rd_en/rd_field/rd_addr   operand-store read request; rd_data returns one cycle later
//   valid_o/ready_i/data_o   outgoing operand stream
//   res_valid_i/res_ready_o/res_data_i   result handshake; res_data_i[0] = reject
//   busy, done, reject, err, cycle_cnt    status
module vy_stream_sequencer #(
  parameter int unsigned W      = 64,
  parameter int unsigned AW     = 12,
  parameter int unsigned MLEN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        sec_lvl,
  input  logic [MLEN_W-1:0] mlen,
  output logic              rd_en,
  output logic [2:0]        rd_field,
  output logic [AW-1:0]     rd_addr,
  input  logic [W-1:0]      rd_data,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [W-1:0]      data_o,
  input  logic              res_valid_i,
  output logic              res_ready_o,
  input  logic [W-1:0]      res_data_i,
  output logic              busy,
  output logic              done,
  output logic              reject,
  output logic              err,
  output logic [31:0]       cycle_cnt
);

  // Wide enough for mlen*8 + W-1 and for every per-field word count.
  localparam int unsigned CW = MLEN_W + 4;

  localparam logic [CW-1:0] N_RHO = CW'(256 / W);
  localparam logic [CW-1:0] N_Z2  = CW'(18432 / W);
  localparam logic [CW-1:0] N_Z3  = CW'(25600 / W);
  localparam logic [CW-1:0] N_Z5  = CW'(35840 / W);
  localparam logic [CW-1:0] N_T2  = CW'(10240 / W);
  localparam logic [CW-1:0] N_T3  = CW'(15360 / W);
  localparam logic [CW-1:0] N_T5  = CW'(20480 / W);
  localparam logic [CW-1:0] N_H2  = CW'((672 + W - 1) / W);
  localparam logic [CW-1:0] N_H3  = CW'((488 + W - 1) / W);
  localparam logic [CW-1:0] N_H5  = CW'((664 + W - 1) / W);

  localparam logic [2:0] F_RHO  = 3'd0;
  localparam logic [2:0] F_C    = 3'd1;
  localparam logic [2:0] F_Z    = 3'd2;
  localparam logic [2:0] F_T1   = 3'd3;
  localparam logic [2:0] F_MLEN = 3'd4;
  localparam logic [2:0] F_M    = 3'd5;
  localparam logic [2:0] F_H    = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT_RES, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        lvl_q;        // 0: level 2, 1: level 3, 2: level 5
  logic [MLEN_W-1:0] mlen_q;
  logic [2:0]        fld_q;        // field currently being issued
  logic [CW-1:0]     addr_q;       // word index within fld_q
  logic              iss_done_q;   // last h word has been issued
  logic              pend_q;       // a word lands in the FIFO this cycle
  logic              pend_gen_q;   // ...and it is the internally generated mlen word
  logic [W-1:0]      fifo_q [2];
  logic              wptr_q, rptr_q;
  logic [1:0]        occ_q;

  logic              lvl_ok_c, can_start_c, start_ok_c, pop_c, issue_c, last_c;
  logic [1:0]        lvl_sel_c;
  logic [2:0]        slots_c;
  logic [CW-1:0]     m_bits_c, m_words_c, fld_words_c;
  logic              unused_res;

  assign unused_res = ^res_data_i[W-1:1];

  // Security-level decode.
  always_comb begin
    lvl_ok_c  = 1'b1;
    lvl_sel_c = 2'd0;
    case (sec_lvl)
      3'd2:    lvl_sel_c = 2'd0;
      3'd3:    lvl_sel_c = 2'd1;
      3'd5:    lvl_sel_c = 2'd2;
      default: lvl_ok_c  = 1'b0;
    endcase
  end

  // Word count of the field being issued; an empty message still sends one word.
  always_comb begin
    m_bits_c  = (CW'(mlen_q) << 3) + CW'(W - 1);
    m_words_c = m_bits_c / CW'(W);
    if (m_words_c == '0) m_words_c = CW'(1);
    fld_words_c = CW'(1);
    case (fld_q)
      F_RHO, F_C: fld_words_c = N_RHO;
      F_Z:        fld_words_c = (lvl_q == 2'd0) ? N_Z2 : (lvl_q == 2'd1) ? N_Z3 : N_Z5;
      F_T1:       fld_words_c = (lvl_q == 2'd0) ? N_T2 : (lvl_q == 2'd1) ? N_T3 : N_T5;
      F_MLEN:     fld_words_c = CW'(1);
      F_M:        fld_words_c = m_words_c;
      F_H:        fld_words_c = (lvl_q == 2'd0) ? N_H2 : (lvl_q == 2'd1) ? N_H3 : N_H5;
      default:    fld_words_c = CW'(1);
    endcase
  end

  // Issue a slot only if the FIFO can hold it once the in-flight word lands.
  always_comb begin
    can_start_c = start && (state_q == S_IDLE || state_q == S_DONE);
    start_ok_c  = can_start_c && lvl_ok_c;
    pop_c       = valid_o && ready_i;
    slots_c     = 3'(occ_q) + 3'(pend_q);
    issue_c     = (state_q == S_STREAM) && !iss_done_q && (slots_c < (3'd2 + 3'(pop_c)));
    last_c      = (addr_q == fld_words_c - CW'(1));
  end

  assign rd_en       = issue_c && (fld_q != F_MLEN);
  assign rd_field    = fld_q;
  assign rd_addr     = AW'(addr_q);
  assign valid_o     = (occ_q != 2'd0);
  assign data_o      = fifo_q[rptr_q];
  assign res_ready_o = (state_q == S_WAIT_RES);
  assign busy        = (state_q == S_STREAM) || (state_q == S_WAIT_RES);
  assign done        = (state_q == S_DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; STREAM ends when the final h word leaves the FIFO.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok_c)       state_d = S_STREAM;
        else if (can_start_c) state_d = S_IDLE;
      end
      S_STREAM: begin
        if (iss_done_q && !pend_q && occ_q == 2'd1 && pop_c) state_d = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (res_valid_i) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Issue counters, read pipeline, output FIFO and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q      <= 2'd0;
      mlen_q     <= '0;
      fld_q      <= F_RHO;
      addr_q     <= '0;
      iss_done_q <= 1'b0;
      pend_q     <= 1'b0;
      pend_gen_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      occ_q      <= 2'd0;
      err        <= 1'b0;
      reject     <= 1'b0;
      cycle_cnt  <= 32'd0;
    end else begin
      if (can_start_c) begin
        err <= !lvl_ok_c;
        if (lvl_ok_c) begin
          lvl_q      <= lvl_sel_c;
          mlen_q     <= mlen;
          fld_q      <= F_RHO;
          addr_q     <= '0;
          iss_done_q <= 1'b0;
          reject     <= 1'b0;
          cycle_cnt  <= 32'd0;
        end
      end

      if (issue_c) begin
        if (last_c) begin
          addr_q <= '0;
          if (fld_q == F_H) iss_done_q <= 1'b1;
          else              fld_q      <= fld_q + 3'd1;
        end else begin
          addr_q <= addr_q + CW'(1);
        end
      end

      pend_q     <= issue_c;
      pend_gen_q <= issue_c && (fld_q == F_MLEN);

      if (pend_q) begin
        fifo_q[wptr_q] <= pend_gen_q ? W'(mlen_q) : rd_data;
        wptr_q         <= ~wptr_q;
      end
      if (pop_c) rptr_q <= ~rptr_q;
      occ_q <= occ_q + {1'b0, pend_q} - {1'b0, pop_c};

      if (state_q == S_STREAM || state_q == S_WAIT_RES) cycle_cnt <= cycle_cnt + 32'd1;
      if (state_q == S_WAIT_RES && res_valid_i)         reject    <= res_data_i[0];
    end
  end

endmodule

// File: tb/tb_vy_stream_sequencer.sv
// tb_vy_stream_sequencer
//   Directed bench for vy_stream_sequencer: a W=64 and a W=32 instance share
//   the control inputs, each with its own start and a one-cycle-latency store.
module tb_vy_stream_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start64, start32, ready, res_valid;
  logic [2:0]  lvl;
  logic [15:0] ml;
  logic [63:0] res_data;

  logic        rd_en64, valid64, res_ready64, busy64, done64, reject64, err64;
  logic [2:0]  rd_field64;
  logic [11:0] rd_addr64;
  logic [63:0] rd_data64, data64;
  logic [31:0] cnt64;

  logic        rd_en32, valid32, res_ready32, busy32, done32, reject32, err32;
  logic [2:0]  rd_field32;
  logic [11:0] rd_addr32;
  logic [31:0] rd_data32, data32;
  logic [31:0] cnt32;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit sel32    = 1'b0;

  vy_stream_sequencer #(.W(64), .AW(12), .MLEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start64), .sec_lvl(lvl), .mlen(ml),
    .rd_en(rd_en64), .rd_field(rd_field64), .rd_addr(rd_addr64), .rd_data(rd_data64),
    .valid_o(valid64), .ready_i(ready), .data_o(data64),
    .res_valid_i(res_valid), .res_ready_o(res_ready64), .res_data_i(res_data),
    .busy(busy64), .done(done64), .reject(reject64), .err(err64), .cycle_cnt(cnt64)
  );

  vy_stream_sequencer #(.W(32), .AW(12), .MLEN_W(16)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .sec_lvl(lvl), .mlen(ml),
    .rd_en(rd_en32), .rd_field(rd_field32), .rd_addr(rd_addr32), .rd_data(rd_data32),
    .valid_o(valid32), .ready_i(ready), .data_o(data32),
    .res_valid_i(res_valid), .res_ready_o(res_ready32), .res_data_i(res_data[31:0]),
    .busy(busy32), .done(done32), .reject(reject32), .err(err32), .cycle_cnt(cnt32)
  );

  // Store contents encode field and address so the read sequence is visible in the data.
  function automatic logic [63:0] pat(input logic [2:0] f, input logic [11:0] a, input bit s32);
    if (s32) return {32'h0, 5'h0, f, 8'hA5, 4'h0, a};
    return {5'h0, f, 24'hA5C3E1, 20'h0, a};
  endfunction

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    rd_data64 <= rd_en64 ? pat(rd_field64, rd_addr64, 1'b0) : 64'hBAD0_BAD0_BAD0_BAD0;
    rd_data32 <= rd_en32 ? 32'(pat(rd_field32, rd_addr32, 1'b1)) : 32'hBAD0_BAD0;
  end

  logic        v_s, re_s, busy_s, done_s, rej_s, err_s, rr_s;
  logic [63:0] d_s;
  logic [31:0] cnt_s;
  assign v_s    = sel32 ? valid32     : valid64;
  assign re_s   = sel32 ? rd_en32     : rd_en64;
  assign busy_s = sel32 ? busy32      : busy64;
  assign done_s = sel32 ? done32      : done64;
  assign rej_s  = sel32 ? reject32    : reject64;
  assign err_s  = sel32 ? err32       : err64;
  assign rr_s   = sel32 ? res_ready32 : res_ready64;
  assign d_s    = sel32 ? {32'h0, data32} : data64;
  assign cnt_s  = sel32 ? cnt32       : cnt64;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One verification: launch, follow every beat against the field/word model, take the result.
  task automatic run(input bit s32, input logic [2:0] lv, input logic [15:0] mln,
                     input int n0, input int n1, input int n2, input int n3,
                     input int n5, input int n6, input bit rnd, input int abort_at,
                     input int poke_at, input bit resv, input bit exact);
    int cnt [7];
    int total, f, a, beats, reads, gaps, extra, t0, tfirst, tlast, tcap;
    bit bad, stalled, seen, poke_now, poked;
    logic [63:0] held, expd;
    cnt = '{n0, n1, n2, n3, 1, n5, n6};
    total = 0;
    foreach (cnt[i]) total += cnt[i];
    f = 0; a = 0; beats = 0; reads = 0; gaps = 0; extra = 0;
    tfirst = -1; tlast = -1;
    bad = 1'b0; stalled = 1'b0; seen = 1'b0; poked = 1'b0;
    held = '0;
    sel32 = s32; lvl = lv; ml = mln; ready = 1'b1;

    @(posedge clk); #1;
    if (s32) start32 = 1'b1; else start64 = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start32 = 1'b0; start64 = 1'b0;
    chk("busy_after_start", 64'(busy_s), 64'd1);
    chk("err_clear_on_start", 64'(err_s), 64'd0);
    chk("done_clear_on_start", 64'(done_s), 64'd0);

    for (int k = 0; k < 20000 && beats < total; k++) begin
      @(negedge clk);
      if (re_s) reads++;
      if (stalled && !bad) begin
        chk("stall_hold", v_s ? d_s : ~held, held);
        if (!v_s || d_s !== held) bad = 1'b1;
      end
      if (v_s && !seen) begin seen = 1'b1; tfirst = cyc; end
      if (seen && !v_s) gaps++;
      if (v_s && ready) begin
        expd = (f == 4) ? 64'(ml) : pat(3'(f), 12'(a), s32);
        if (!bad) begin
          chk("beat_data", d_s, expd);
          if (d_s !== expd) bad = 1'b1;
        end
        if (mln == 16'd33 && beats == 456) chk("beat457_mlen", d_s, 64'h21);
        beats++;
        tlast = cyc;
        a = a + 1;
        if (a == cnt[f]) begin a = 0; f++; end
      end
      stalled = v_s && !ready;
      held = d_s;
      if (abort_at != 0 && beats == abort_at) begin
        #1 rst = 1'b1;
        #1;
        chk("abort_valid", 64'(v_s), 64'd0);
        chk("abort_rd_en", 64'(re_s), 64'd0);
        chk("abort_busy", 64'(busy_s), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; ready = 1'b1;
        return;
      end
      poke_now = (poke_at != 0 && beats >= poke_at && !poked);
      if (poke_now) poked = 1'b1;
      @(posedge clk); #1;
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s32) start32 = poke_now; else start64 = poke_now;
    end
    start32 = 1'b0; start64 = 1'b0; ready = 1'b1;

    chk("beat_count", 64'(beats), 64'(total));
    chk("first_valid_latency", 64'(tfirst - t0), 64'd2);
    if (!rnd) chk("no_gaps", 64'(gaps), 64'd0);
    if (exact) chk("last_beat_cycle", 64'(tlast - t0), 64'(total + 1));

    repeat (4) begin
      @(negedge clk);
      if (v_s) extra++;
      if (re_s) reads++;
    end
    chk("no_extra_valid", 64'(extra), 64'd0);
    chk("read_count", 64'(reads), 64'(total - 1));
    chk("res_ready_wait", 64'(rr_s), 64'd1);
    chk("busy_wait", 64'(busy_s), 64'd1);

    @(posedge clk); #1;
    res_valid = 1'b1;
    res_data  = {63'h2AAA_AAAA_AAAA_AAAA, resv};
    @(posedge clk); #1;
    tcap = cyc;
    res_valid = 1'b0;
    chk("done", 64'(done_s), 64'd1);
    chk("reject", 64'(rej_s), 64'(resv));
    chk("busy_in_done", 64'(busy_s), 64'd0);
    chk("res_ready_drop", 64'(rr_s), 64'd0);
    chk("cycle_cnt", 64'(cnt_s), 64'(tcap - t0));
    repeat (3) @(posedge clk);
    #1;
    chk("cycle_cnt_frozen", 64'(cnt_s), 64'(tcap - t0));
    chk("done_level", 64'(done_s), 64'd1);
  endtask

  initial begin
    int rdn;
    rst = 1'b1; start64 = 1'b0; start32 = 1'b0; ready = 1'b1;
    res_valid = 1'b0; res_data = '0; lvl = 3'd2; ml = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_rd_en", 64'(rd_en64), 64'd0);
    chk("rst_valid", 64'(valid64), 64'd0);
    chk("rst_data", data64, 64'd0);
    chk("rst_busy", 64'(busy64), 64'd0);
    chk("rst_done", 64'(done64), 64'd0);
    chk("rst_reject", 64'(reject64), 64'd0);
    chk("rst_err", 64'(err64), 64'd0);
    chk("rst_cycle_cnt", 64'(cnt64), 64'd0);
    chk("rst_res_ready", 64'(res_ready64), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr64), 64'd0);
    chk("rst_valid32", 64'(valid32), 64'd0);
    chk("rst_busy32", 64'(busy32), 64'd0);
    rst = 1'b0;

    // W=64, level 2, 33-byte message, sink always ready: 473 back-to-back beats
    run(1'b0, 3'd2, 16'd33, 4, 4, 288, 160, 5, 11, 1'b0, 0, 0, 1'b0, 1'b1);

    // Illegal level: error flag, no reads, stays idle
    sel32 = 1'b0; lvl = 3'd4;
    @(posedge clk); #1 start64 = 1'b1;
    @(posedge clk); #1 start64 = 1'b0;
    chk("illegal_err", 64'(err64), 64'd1);
    chk("illegal_busy", 64'(busy64), 64'd0);
    rdn = 0;
    repeat (5) begin
      @(negedge clk);
      if (rd_en64 || valid64) rdn++;
    end
    chk("illegal_no_activity", 64'(rdn), 64'd0);
    chk("illegal_err_sticky", 64'(err64), 64'd1);

    // Level 2 clears err; a start pulse mid-stream must be ignored
    run(1'b0, 3'd2, 16'd9, 4, 4, 288, 160, 2, 11, 1'b0, 0, 50, 1'b1, 1'b1);

    // Level 3, empty message, random backpressure, reject result
    run(1'b0, 3'd3, 16'd0, 4, 4, 400, 240, 1, 8, 1'b1, 0, 0, 1'b1, 1'b0);

    // Reset at beat 100, then a fresh level-5 run from rho word 0
    run(1'b0, 3'd2, 16'd33, 4, 4, 288, 160, 5, 11, 1'b0, 100, 0, 1'b0, 1'b1);
    chk("post_abort_done", 64'(done64), 64'd0);
    run(1'b0, 3'd5, 16'd200, 4, 4, 560, 320, 25, 11, 1'b0, 0, 0, 1'b0, 1'b1);

    // W=32, level 5, 8-byte message
    run(1'b1, 3'd5, 16'd8, 8, 8, 1120, 640, 2, 21, 1'b0, 0, 0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
